// File: rtl/rv_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I decode hazard controller.
// Holds the flush FSM state encoding and register-file geometry.
package rv_hazard_ctrl_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int PEND_W   = 4;
    localparam int FCNT_W   = 3;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_e;

    // One-hot mask selecting architectural register addr.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rv_hazard_ctrl_scoreboard.sv
// Load scoreboard: per-register busy bits, saturating outstanding-load count
// and a sticky protocol error flag.
module rv_scoreboard
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_issue,
    input  logic                i_issue_load,
    input  logic [REG_AW-1:0]   i_issue_rd,
    input  logic                i_wb_valid,
    input  logic [REG_AW-1:0]   i_wb_rd,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [PEND_W-1:0]   o_pending,
    output logic                o_err
);

    localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [PEND_W-1:0]   pending_reg;
    logic [PEND_W-1:0]   pending_next;
    logic                err_reg;
    logic                err_next;
    logic                load_issue;
    logic                at_max;
    logic                at_zero;
    logic                wb_orphan;

    assign load_issue = i_issue && i_issue_load;
    assign at_max     = (pending_reg == MAX_P);
    assign at_zero    = (pending_reg == '0);

    // Loads to x0 count toward pending but never mark the register busy.
    assign set_mask = (load_issue && (i_issue_rd != '0)) ? reg_mask(i_issue_rd) : '0;
    assign clr_mask = i_wb_valid ? reg_mask(i_wb_rd) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            // The newer load owns the register when set and clear collide.
            assign busy_next[gi] = set_mask[gi] | (busy_reg[gi] & ~clr_mask[gi]);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    busy_reg[gi] <= 1'b0;
                end else begin
                    busy_reg[gi] <= busy_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        pending_next = pending_reg;
        if (load_issue && !i_wb_valid && !at_max) begin
            pending_next = pending_reg + 4'd1;
        end else if (!load_issue && i_wb_valid && !at_zero) begin
            pending_next = pending_reg - 4'd1;
        end
    end

    assign wb_orphan = i_wb_valid && (i_wb_rd != '0) &&
                       !busy_reg[i_wb_rd] && !set_mask[i_wb_rd];

    assign err_next = err_reg
                    | (i_wb_valid && at_zero)
                    | wb_orphan
                    | (load_issue && at_max);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            err_reg     <= err_next;
        end
    end

    assign o_busy    = busy_reg;
    assign o_pending = pending_reg;
    assign o_err     = err_reg;

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Decode-stage hazard controller: RAW and load-capacity stalls plus a
// multi-cycle front-end flush sequencer triggered by redirects.
module rv_hazard_ctrl
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dec_valid,
    input  logic [REG_AW-1:0]   i_dec_rs1_addr,
    input  logic [REG_AW-1:0]   i_dec_rs2_addr,
    input  logic                i_dec_load,
    input  logic                i_issue,
    input  logic                i_issue_load,
    input  logic [REG_AW-1:0]   i_issue_rd,
    input  logic                i_wb_valid,
    input  logic [REG_AW-1:0]   i_wb_rd,
    input  logic                i_redirect,
    input  logic                i_ext_stall,
    output logic                o_stall_dec,
    output logic                o_flush,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [PEND_W-1:0]   o_pending,
    output logic                o_err
);

    localparam logic [PEND_W-1:0] MAX_P        = PEND_W'(MAX_OUTSTANDING);
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    hz_state_e           state_reg;
    hz_state_e           state_next;
    logic [FCNT_W-1:0]   cnt_reg;
    logic [FCNT_W-1:0]   cnt_next;
    logic [NUM_REGS-1:0] busy;
    logic [PEND_W-1:0]   pending;
    logic                raw_hz;
    logic                cap_hz;

    rv_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_issue      (i_issue),
        .i_issue_load (i_issue_load),
        .i_issue_rd   (i_issue_rd),
        .i_wb_valid   (i_wb_valid),
        .i_wb_rd      (i_wb_rd),
        .o_busy       (busy),
        .o_pending    (pending),
        .o_err        (o_err)
    );

    // No writeback bypass: a register is released only the cycle after its writeback.
    assign raw_hz = i_dec_valid &&
                    ((busy[i_dec_rs1_addr] && (i_dec_rs1_addr != '0)) ||
                     (busy[i_dec_rs2_addr] && (i_dec_rs2_addr != '0)));

    assign cap_hz = i_dec_valid && i_dec_load && (pending == MAX_P) && !i_wb_valid;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            HZ_RUN: begin
                if (i_redirect) begin
                    state_next = HZ_FLUSH;
                    cnt_next   = FLUSH_RELOAD;
                end
            end
            HZ_FLUSH: begin
                if (i_redirect) begin
                    cnt_next = FLUSH_RELOAD;
                end else if (cnt_reg == '0) begin
                    state_next = HZ_RUN;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= HZ_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign o_flush     = (state_reg == HZ_FLUSH);
    assign o_stall_dec = (raw_hz || cap_hz || i_ext_stall) && (state_reg == HZ_RUN);
    assign o_busy      = busy;
    assign o_pending   = pending;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed vector table, hand-written
// flush/reset sequences and randomized traffic against a rule-level model.
module tb_rv_hazard_ctrl;

    localparam int MAXO = 4;
    localparam int FC   = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_dec_valid = 1'b0;
    logic [4:0]  i_dec_rs1_addr = '0;
    logic [4:0]  i_dec_rs2_addr = '0;
    logic        i_dec_load = 1'b0;
    logic        i_issue = 1'b0;
    logic        i_issue_load = 1'b0;
    logic [4:0]  i_issue_rd = '0;
    logic        i_wb_valid = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic        i_redirect = 1'b0;
    logic        i_ext_stall = 1'b0;
    logic        o_stall_dec;
    logic        o_flush;
    logic [31:0] o_busy;
    logic [3:0]  o_pending;
    logic        o_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    rv_hazard_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .FLUSH_CYCLES    (FC)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_dec_valid    (i_dec_valid),
        .i_dec_rs1_addr (i_dec_rs1_addr),
        .i_dec_rs2_addr (i_dec_rs2_addr),
        .i_dec_load     (i_dec_load),
        .i_issue        (i_issue),
        .i_issue_load   (i_issue_load),
        .i_issue_rd     (i_issue_rd),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd        (i_wb_rd),
        .i_redirect     (i_redirect),
        .i_ext_stall    (i_ext_stall),
        .o_stall_dec    (o_stall_dec),
        .o_flush        (o_flush),
        .o_busy         (o_busy),
        .o_pending      (o_pending),
        .o_err          (o_err)
    );

    typedef struct {
        logic        dv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        dl;
        logic        iss;
        logic        il;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wrd;
        logic        es;
        logic        exp_stall;
        logic [31:0] exp_busy;
        logic [3:0]  exp_pend;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic dl, input logic iss, input logic il,
                                input logic [4:0] ird, input logic wv, input logic [4:0] wrd,
                                input logic es, input logic st, input logic [31:0] busy,
                                input logic [3:0] pend, input logic err);
        vec_t v;
        v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.dl = dl; v.iss = iss; v.il = il;
        v.ird = ird; v.wv = wv; v.wrd = wrd; v.es = es;
        v.exp_stall = st; v.exp_busy = busy; v.exp_pend = pend; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_dec_valid = 0; i_dec_rs1_addr = 0; i_dec_rs2_addr = 0; i_dec_load = 0;
        i_issue = 0; i_issue_load = 0; i_issue_rd = 0; i_wb_valid = 0; i_wb_rd = 0;
        i_redirect = 0; i_ext_stall = 0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        idle_inputs();
        i_rst_n = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1;
    endtask

    // Advance to the next cycle's drive point (mid-cycle, away from the active edge).
    task automatic next_cycle();
        @(negedge i_clk);
        idle_inputs();
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_busy;
    int        m_pend;
    bit        m_err;
    int        m_flush_left;

    task automatic model_reset();
        m_busy = '0; m_pend = 0; m_err = 0; m_flush_left = 0;
    endtask

    task automatic model_step();
        bit ld;
        ld = i_issue && i_issue_load;
        if (i_wb_valid && m_pend == 0) m_err = 1;
        if (i_wb_valid && i_wb_rd != 0 && !m_busy[i_wb_rd] &&
            !(ld && i_issue_rd == i_wb_rd)) m_err = 1;
        if (ld && m_pend == MAXO) m_err = 1;
        if (i_wb_valid) m_busy[i_wb_rd] = 1'b0;
        if (ld && i_issue_rd != 0) m_busy[i_issue_rd] = 1'b1;
        if (ld && !i_wb_valid) m_pend = (m_pend + 1 > MAXO) ? MAXO : m_pend + 1;
        if (!ld && i_wb_valid) m_pend = (m_pend - 1 < 0) ? 0 : m_pend - 1;
        if (i_redirect) m_flush_left = FC;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    initial begin
        int q_rd[$];
        int idx;
        bit raw, cap, exp_stall;

        // rows: dv rs1 rs2 dl iss il ird wv wrd es | stall busy pend err
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5, 0, 0, 0,  0, 32'h0,     0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h20,    1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h20,    1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h20,    1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 5, 0,  1, 32'h20,    1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,     1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 7, 1, 7, 0,  0, 32'h0,     1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,    1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 32'h80,    1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  0, 32'h0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 0, 0,  0, 32'h2,     1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0,  0, 32'h6,     2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0, 0, 0,  0, 32'hE,     3, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 32'h1E,    4, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 8, 1, 1, 0,  0, 32'h1E,    4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h11C,   4, 1));
        tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0,  1, 32'h11C,   4, 1));
        tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h11C,   4, 1));
        tbl.push_back(mk(1, 9, 31, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11C,   4, 1));

        // ---------------- directed vector table ----------------
        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            next_cycle();
            i_dec_valid = tbl[r].dv; i_dec_rs1_addr = tbl[r].rs1; i_dec_rs2_addr = tbl[r].rs2;
            i_dec_load = tbl[r].dl; i_issue = tbl[r].iss; i_issue_load = tbl[r].il;
            i_issue_rd = tbl[r].ird; i_wb_valid = tbl[r].wv; i_wb_rd = tbl[r].wrd;
            i_ext_stall = tbl[r].es;
            #1;
            chk($sformatf("vec%0d_stall", r), 32'(o_stall_dec), 32'(tbl[r].exp_stall));
            chk($sformatf("vec%0d_flush", r), 32'(o_flush), 32'h0);
            chk($sformatf("vec%0d_busy", r), o_busy, tbl[r].exp_busy);
            chk($sformatf("vec%0d_pend", r), 32'(o_pending), 32'(tbl[r].exp_pend));
            chk($sformatf("vec%0d_err", r), 32'(o_err), 32'(tbl[r].exp_err));
            $display("vec %0d: stall=%0b busy=%08h pend=%0d err=%0b",
                     r, o_stall_dec, o_busy, o_pending, o_err);
        end

        // ---------------- flush timing, redirect extension, flush over stall ----------------
        do_reset();
        begin
            // per cycle: redirect, ext_stall, expected flush, expected stall
            bit seq_rd[9] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
            bit seq_es[9] = '{0, 1, 1, 1, 0, 0, 0, 0, 1};
            bit seq_fl[9] = '{0, 1, 1, 0, 0, 1, 1, 1, 0};
            bit seq_st[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
            for (int c = 0; c < 9; c++) begin
                next_cycle();
                i_redirect = seq_rd[c];
                i_ext_stall = seq_es[c];
                #1;
                chk($sformatf("flush_c%0d", c), 32'(o_flush), 32'(seq_fl[c]));
                chk($sformatf("flush_stall_c%0d", c), 32'(o_stall_dec), 32'(seq_st[c]));
                $display("flush seq %0d: redirect=%0b flush=%0b stall=%0b",
                         c, seq_rd[c], o_flush, o_stall_dec);
            end
        end

        // ---------------- sticky error then async reset mid-flush ----------------
        do_reset();
        next_cycle();
        i_wb_valid = 1; i_wb_rd = 3;
        #1 chk("err_before", 32'(o_err), 32'h0);
        next_cycle();
        i_issue = 1; i_issue_load = 1; i_issue_rd = 6;
        #1 chk("err_set", 32'(o_err), 32'h1);
        next_cycle();
        i_redirect = 1;
        #1;
        chk("err_hold", 32'(o_err), 32'h1);
        chk("busy6", o_busy, 32'h40);
        chk("pend1", 32'(o_pending), 32'h1);
        next_cycle();
        #1 chk("flush_pre_rst", 32'(o_flush), 32'h1);
        chk("err_hold2", 32'(o_err), 32'h1);
        #1 i_rst_n = 0;
        #1;
        chk("arst_flush", 32'(o_flush), 32'h0);
        chk("arst_err", 32'(o_err), 32'h0);
        chk("arst_busy", o_busy, 32'h0);
        chk("arst_pend", 32'(o_pending), 32'h0);
        chk("arst_stall", 32'(o_stall_dec), 32'h0);
        $display("async reset mid-flush: flush=%0b err=%0b busy=%08h pend=%0d",
                 o_flush, o_err, o_busy, o_pending);
        @(negedge i_clk);
        i_rst_n = 1;

        // ---------------- randomized traffic vs model ----------------
        for (int ep = 0; ep < 10; ep++) begin
            do_reset();
            model_reset();
            q_rd.delete();
            for (int c = 0; c < 300; c++) begin
                next_cycle();
                i_dec_valid = ($urandom_range(0, 2) != 0);
                i_dec_rs1_addr = 5'($urandom_range(0, 7));
                i_dec_rs2_addr = 5'($urandom_range(0, 7));
                i_dec_load = $urandom_range(0, 1) == 1;
                if (q_rd.size() < MAXO || $urandom_range(0, 9) == 0) begin
                    i_issue = $urandom_range(0, 2) == 0;
                    i_issue_load = $urandom_range(0, 1) == 1;
                    i_issue_rd = 5'($urandom_range(0, 7));
                end
                if (q_rd.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, q_rd.size() - 1);
                    i_wb_valid = 1;
                    i_wb_rd = 5'(q_rd[idx]);
                    q_rd.delete(idx);
                end else if ($urandom_range(0, 59) == 0) begin
                    i_wb_valid = 1;
                    i_wb_rd = 5'($urandom_range(0, 31));
                end
                if (i_issue && i_issue_load && q_rd.size() < MAXO) q_rd.push_back(int'(i_issue_rd));
                i_redirect = $urandom_range(0, 11) == 0;
                i_ext_stall = $urandom_range(0, 7) == 0;
                #1;
                raw = i_dec_valid && ((m_busy[i_dec_rs1_addr] && i_dec_rs1_addr != 0) ||
                                      (m_busy[i_dec_rs2_addr] && i_dec_rs2_addr != 0));
                cap = i_dec_valid && i_dec_load && m_pend == MAXO && !i_wb_valid;
                exp_stall = (raw || cap || i_ext_stall) && m_flush_left == 0;
                chk("rnd_stall", 32'(o_stall_dec), 32'(exp_stall));
                chk("rnd_flush", 32'(o_flush), 32'(m_flush_left > 0));
                chk("rnd_busy", o_busy, m_busy);
                chk("rnd_pend", 32'(o_pending), 32'(m_pend));
                chk("rnd_err", 32'(o_err), 32'(m_err));
                @(posedge i_clk);
                model_step();
            end
            $display("random episode %0d: pend=%0d err=%0b busy=%08h", ep, m_pend, m_err, m_busy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
